pll_reset_sequencer: RTL and testbench

//  Drives the system PLL's active-high reset, waits for a stable, synchronized lock, then releases
//  the downstream reset domains one after another: stage 0 is sys, stage 1 is memory, stage 2 is video.

---
 rtl/pll_rst_seq_pkg.sv | 25 ++
 rtl/bit_sync_2ff.sv | 23 ++
 rtl/pll_reset_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_seq_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
// State codes are visible on the seq_state debug port.
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3
  } seq_state_t;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_STAGE_GAP_CYCLES    = 64;
  localparam int unsigned DEF_NUM_STAGES          = 3;
  localparam int unsigned DEF_CNT_W               = 17;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop level synchronizer, clears to 0 on async reset.
// Used to bring pll_locked into the reference clock domain.
module bit_sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture of an asynchronous level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset and staged downstream reset release sequencer.
// Optional status counters: define PLL_RST_SEQ_STATUS_EN.
module pll_reset_sequencer
  import pll_rst_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES,
  parameter int unsigned NUM_STAGES          = DEF_NUM_STAGES,
  parameter int unsigned CNT_W               = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  ready,
  output logic [2:0]            seq_state
`ifdef PLL_RST_SEQ_STATUS_EN
  ,
  output logic [7:0]            lock_loss_cnt,
  output logic [7:0]            timeout_cnt
`endif
);

  localparam logic [CNT_W-1:0] RST_LOAD =
    CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LOAD =
    CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD =
    CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [NUM_STAGES-1:0] ALL_REL = '1;

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tmo;
  logic             lock_s;
  logic             loss;
  logic             stable_done;
  logic             timeout;

  bit_sync_2ff u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_s)
  );

  assign seq_state = state;

  assign loss = !lock_s &&
    ((state == RELEASE) || (state == RUN));

  assign stable_done = (state == WAIT_LOCK) &&
    lock_s && (cnt == '0);

  // a lock that completes on the last allowed cycle beats the retry
  assign timeout = (state == WAIT_LOCK) &&
    (tmo == TMO_LAST) && !stable_done;

  // sequencer: PLL reset, lock qualification, staged release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= PLL_RST;
      cnt           <= RST_LOAD;
      tmo           <= '0;
      pll_rst       <= 1'b1;
      stage_reset_n <= '0;
      ready         <= 1'b0;
    end else if (sw_reset_req) begin
      state         <= PLL_RST;
      cnt           <= RST_LOAD;
      pll_rst       <= 1'b1;
      stage_reset_n <= '0;
      ready         <= 1'b0;
    end else begin
      unique case (state)
        PLL_RST: begin
          if (cnt == '0) begin
            state   <= WAIT_LOCK;
            cnt     <= STB_LOAD;
            tmo     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          tmo <= tmo + CNT_W'(1);
          if (stable_done) begin
            state         <= RELEASE;
            cnt           <= GAP_LOAD;
            stage_reset_n <= NUM_STAGES'(1);
          end else if (timeout) begin
            state   <= PLL_RST;
            cnt     <= RST_LOAD;
            pll_rst <= 1'b1;
          end else if (!lock_s) begin
            cnt <= STB_LOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RELEASE: begin
          if (loss) begin
            state         <= PLL_RST;
            cnt           <= RST_LOAD;
            pll_rst       <= 1'b1;
            stage_reset_n <= '0;
            ready         <= 1'b0;
          end else if (stage_reset_n == ALL_REL) begin
            state <= RUN;
            ready <= 1'b1;
          end else if (cnt == '0) begin
            cnt           <= GAP_LOAD;
            stage_reset_n <=
              (stage_reset_n << 1) | NUM_STAGES'(1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RUN: begin
          if (loss) begin
            state         <= PLL_RST;
            cnt           <= RST_LOAD;
            pll_rst       <= 1'b1;
            stage_reset_n <= '0;
            ready         <= 1'b0;
          end
        end
        default: begin
          state         <= PLL_RST;
          cnt           <= RST_LOAD;
          pll_rst       <= 1'b1;
          stage_reset_n <= '0;
          ready         <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_RST_SEQ_STATUS_EN
  // saturating counts of RUN lock losses and lock timeouts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_cnt <= 8'd0;
      timeout_cnt   <= 8'd0;
    end else begin
      if (loss && (state == RUN))
        lock_loss_cnt <= sat_inc(lock_loss_cnt);
      if (timeout)
        timeout_cnt <= sat_inc(timeout_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized scoreboard bench for pll_reset_sequencer.
// Status counters are checked when PLL_RST_SEQ_STATUS_EN is defined.
module tb_pll_reset_sequencer;

  localparam int RST_C = 4;
  localparam int STB_C = 8;
  localparam int TMO_C = 32;
  localparam int GAP_C = 4;
  localparam int NS    = 3;
  localparam int MAXN  = 16000;
  localparam logic [7:0] RESET_V = 8'b000_1_000_0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pll_locked = 1'b0;
  logic sw_reset_req = 1'b0;
  logic pll_rst;
  logic [NS-1:0] stage_reset_n;
  logic ready;
  logic [2:0] seq_state;
`ifdef PLL_RST_SEQ_STATUS_EN
  logic [7:0] lock_loss_cnt;
  logic [7:0] timeout_cnt;
`endif

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (RST_C),
    .LOCK_STABLE_CYCLES  (STB_C),
    .LOCK_TIMEOUT_CYCLES (TMO_C),
    .STAGE_GAP_CYCLES    (GAP_C),
    .NUM_STAGES          (NS),
    .CNT_W               (17)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .sw_reset_req  (sw_reset_req),
    .pll_rst       (pll_rst),
    .stage_reset_n (stage_reset_n),
    .ready         (ready),
    .seq_state     (seq_state)
`ifdef PLL_RST_SEQ_STATUS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt),
    .timeout_cnt   (timeout_cnt)
`endif
  );

  always #10 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } ev_t;

  ev_t        exp_q[$];
  bit         lk [MAXN];
  bit         sw [MAXN];
  logic [7:0] ov [MAXN];
  int n_cyc;
  int cur;
  bit mon_en;
  logic [7:0] mprev;
  int tests = 0;
  int fails = 0;
  int exp_ll;
  int exp_to;
  int rel_first;

  function automatic bit ls(input int c);
    return (c >= 2 && c - 2 < n_cyc) ? lk[c-2] : 1'b0;
  endfunction

  function automatic bit swb(input int c);
    return (c < n_cyc) ? sw[c] : 1'b0;
  endfunction

  function automatic bit stable(input int c);
    for (int k = 0; k < STB_C; k++)
      if (!ls(c - k)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void put(input int c, input logic [7:0] v);
    if (c < n_cyc) ov[c] = v;
  endfunction

  // timeline model: attempt start s, wait start w, first release r
  task automatic run_model();
    int s, w, r, c, k, nxt, m;
    logic [7:0] v;
    exp_ll = 0;
    exp_to = 0;
    rel_first = -1;
    s = 0;
    while (s < n_cyc) begin
      c = s;
      nxt = -1;
      while (nxt < 0 && c < s + RST_C) begin
        put(c, {3'd0, 1'b1, 3'b000, 1'b0});
        if (swb(c)) nxt = c + 1;
        c++;
      end
      if (nxt >= 0) begin
        s = nxt;
        continue;
      end
      w = s + RST_C;
      r = -1;
      while (nxt < 0 && r < 0 && c <= w + TMO_C - 1) begin
        put(c, {3'd1, 1'b0, 3'b000, 1'b0});
        if (c == w + TMO_C - 1 &&
            !(c >= w + STB_C - 1 && stable(c)) &&
            c + 1 < n_cyc)
          exp_to++;
        if (swb(c)) nxt = c + 1;
        else if (c >= w + STB_C - 1 && stable(c)) r = c + 1;
        else if (c == w + TMO_C - 1) nxt = c + 1;
        c++;
      end
      if (nxt >= 0) begin
        s = nxt;
        continue;
      end
      if (rel_first < 0) rel_first = r;
      c = r;
      while (nxt < 0 && c < n_cyc) begin
        k = c - r;
        if (k >= (NS - 1) * GAP_C + 1) begin
          v = {3'd3, 1'b0, 3'b111, 1'b1};
        end else begin
          m = k / GAP_C + 1;
          v = {3'd2, 1'b0, 3'((1 << m) - 1), 1'b0};
        end
        put(c, v);
        if (!ls(c) && k >= (NS - 1) * GAP_C + 1 &&
            c + 1 < n_cyc)
          exp_ll++;
        if (swb(c) || !ls(c)) nxt = c + 1;
        c++;
      end
      if (nxt < 0) break;
      s = nxt;
    end
    if (exp_ll > 255) exp_ll = 255;
    if (exp_to > 255) exp_to = 255;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // monitor: every output change must match the next expected event
  always @(negedge clk) begin
    logic [7:0] v;
    ev_t e;
    if (mon_en) begin
      v = {seq_state, pll_rst, stage_reset_n, ready};
      if (v !== mprev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_change cyc=%0d got=%b", cur, v);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cur || e.v !== v) begin
            fails++;
            $display("FAIL event cyc=%0d got=%b exp_cyc=%0d exp=%b",
              cur, v, e.cyc, e.v);
          end
        end
        mprev = v;
      end
    end
  end

  task automatic clr(input int n);
    n_cyc = n;
    for (int i = 0; i < n; i++) begin
      lk[i] = 1'b0;
      sw[i] = 1'b0;
    end
  endtask

  task automatic gen_random(input int n);
    int i, len;
    bit v;
    clr(n);
    i = 0;
    v = 1'b0;
    while (i < n) begin
      len = v ? int'($urandom_range(120, 10))
              : int'($urandom_range(50, 1));
      for (int j = 0; j < len && i < n; j++) begin
        lk[i] = v;
        sw[i] = ($urandom_range(199, 0) == 0);
        i++;
      end
      v = ($urandom_range(3, 0) != 0) ? !v : v;
    end
    sw[0] = 1'b0;
  endtask

  task automatic run_scn(input string nm);
    logic [7:0] v;
    int pushes;
    // async reset from wherever the previous scenario stopped
    @(negedge clk);
    #4;
    reset_n = 1'b0;
    sw_reset_req = 1'b0;
    pll_locked = 1'b0;
    #1;
    v = {seq_state, pll_rst, stage_reset_n, ready};
    chk({nm, "_reset_vec"}, int'(v), int'(RESET_V));
`ifdef PLL_RST_SEQ_STATUS_EN
    chk({nm, "_reset_cnts"},
      int'({lock_loss_cnt, timeout_cnt}), 0);
`endif
    run_model();
    exp_q.delete();
    v = RESET_V;
    pushes = 0;
    for (int n = 0; n < n_cyc; n++) begin
      if (ov[n] !== v) begin
        exp_q.push_back('{n, ov[n]});
        pushes++;
        v = ov[n];
      end
    end
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    cur = 0;
    mprev = RESET_V;
    pll_locked = lk[0];
    sw_reset_req = sw[0];
    reset_n = 1'b1;
    mon_en = 1'b1;
    for (int n = 1; n < n_cyc; n++) begin
      @(posedge clk);
      #1;
      cur = n;
      pll_locked = lk[n];
      sw_reset_req = sw[n];
    end
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    sw_reset_req = 1'b0;
    chk({nm, "_missing_events"}, exp_q.size(), 0);
    exp_q.delete();
`ifdef PLL_RST_SEQ_STATUS_EN
    chk({nm, "_lock_loss_cnt"}, int'(lock_loss_cnt), exp_ll);
    chk({nm, "_timeout_cnt"}, int'(timeout_cnt), exp_to);
`endif
  endtask

  initial begin
    mon_en = 1'b0;
    cur = 0;
    mprev = RESET_V;

    // power-up with lock from cycle 2
    clr(80);
    for (int i = 2; i < 80; i++) lk[i] = 1'b1;
    run_scn("powerup");

    // lock never arrives: periodic retries
    clr(200);
    run_scn("no_lock");

    // one-cycle lock glitch during qualification
    clr(80);
    for (int i = 0; i < 80; i++) lk[i] = 1'b1;
    lk[7] = 1'b0;
    run_scn("glitch");

    // lock drop in RUN, then full resequence
    clr(150);
    for (int i = 0; i < 150; i++) lk[i] = (i < 40 || i > 45);
    run_scn("run_loss");

    // software request between stage1 and stage2
    clr(80);
    for (int i = 0; i < 80; i++) lk[i] = 1'b1;
    sw[17] = 1'b1;
    run_scn("sw_mid_release");

    // software request coinciding with a RUN lock loss
    clr(120);
    for (int i = 0; i < 120; i++) lk[i] = (i != 40);
    sw[42] = 1'b1;
    run_scn("sw_and_loss");

    // stop mid-RELEASE; next scenario resets asynchronously there
    clr(200);
    for (int i = 0; i < 200; i++) lk[i] = 1'b1;
    run_model();
    clr(rel_first + 6);
    for (int i = 0; i < n_cyc; i++) lk[i] = 1'b1;
    run_scn("to_mid_release");

    // many RUN lock losses: status counter saturation
    clr(12200);
    for (int i = 0; i < 12200; i++) lk[i] = ((i % 40) < 37);
    run_scn("loss_sat");

    for (int t = 0; t < 8; t++) begin
      gen_random(600);
      run_scn($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
